// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and constants for the pipeline hazard controller
package pipe_pkg;
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] r_count;
    // count events, holding at the maximum once reached
    always_ff @(posedge clk)
        r_count <= rst ? '0 : (inc && r_count != '1) ? r_count + 1'b1 : r_count;
    assign count = r_count;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / redirect / memory-wait stall and flush control with perf counters
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rd,
    input  logic             EX_redirect,
    input  logic             MEM_req,
    input  logic             dmem_ready,
    output logic             PC_stall,
    output logic             IF_ID_stall,
    output logic             IF_ID_flush,
    output logic             ID_EX_stall,
    output logic             ID_EX_flush,
    output logic             EX_MEM_stall,
    output logic             MEM_WB_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TO = WW'(MEM_TIMEOUT);

    state_t        r_state, w_state_nxt;
    logic [WW-1:0] r_wait_cnt, w_wait_nxt;
    logic          r_timeout;
    logic          w_mem_busy, w_lu, w_flush_inc;

    assign w_mem_busy = MEM_req & ~dmem_ready;
    assign w_lu = EX_MemRead & (EX_rd != REG_ZERO) &
                  ((ID_use_rs1 & (ID_rs1 == EX_rd)) | (ID_use_rs2 & (ID_rs2 == EX_rd)));
    assign w_flush_inc = ~rst & ~w_mem_busy & EX_redirect;

    // next state, wait count and prioritised stall/flush controls
    always_comb begin
        PC_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_stall  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_stall = 1'b0;
        MEM_WB_flush = 1'b0;
        w_state_nxt  = w_mem_busy ? ST_MEM_WAIT : ST_RUN;
        w_wait_nxt   = !w_mem_busy ? '0 :
                       (r_state == ST_RUN) ? WW'(1) :
                       (r_wait_cnt == TO) ? r_wait_cnt : r_wait_cnt + 1'b1;
        if (rst) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            MEM_WB_flush = 1'b1;
        end else if (w_mem_busy) begin
            PC_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_stall  = 1'b1;
            EX_MEM_stall = 1'b1;
            MEM_WB_flush = 1'b1;
        end else if (EX_redirect) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
        end else if (w_lu) begin
            PC_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_flush  = 1'b1;
        end
    end

    // state, wait counter and sticky timeout registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_timeout  <= r_timeout | (w_wait_nxt == TO);
        end
    end

    assign mem_timeout = r_timeout;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (PC_stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard priorities, memory wait, timeout and counters
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_rs1, ID_rs2, EX_rd;
    logic       ID_use_rs1, ID_use_rs2, EX_MemRead, EX_redirect, MEM_req, dmem_ready;
    logic       PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush;
    logic       mem_timeout;
    logic [3:0] stall_cnt, flush_cnt;
    int         errors = 0;
    int         checks = 0;

    hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ID_rs1       (ID_rs1),
        .ID_rs2       (ID_rs2),
        .ID_use_rs1   (ID_use_rs1),
        .ID_use_rs2   (ID_use_rs2),
        .EX_MemRead   (EX_MemRead),
        .EX_rd        (EX_rd),
        .EX_redirect  (EX_redirect),
        .MEM_req      (MEM_req),
        .dmem_ready   (dmem_ready),
        .PC_stall     (PC_stall),
        .IF_ID_stall  (IF_ID_stall),
        .IF_ID_flush  (IF_ID_flush),
        .ID_EX_stall  (ID_EX_stall),
        .ID_EX_flush  (ID_EX_flush),
        .EX_MEM_stall (EX_MEM_stall),
        .MEM_WB_flush (MEM_WB_flush),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    // {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush}
    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_RESET  = 7'b0010101;
    localparam logic [6:0] C_LU     = 7'b1100100;
    localparam logic [6:0] C_REDIR  = 7'b0010100;
    localparam logic [6:0] C_FREEZE = 7'b1101011;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic [6:0] exp);
        #1;
        chk(tag, {25'd0, PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush}, {25'd0, exp});
    endtask

    task automatic regs(input string tag, input logic [3:0] s, input logic [3:0] f, input logic t);
        chk({tag, "_stall_cnt"}, {28'd0, stall_cnt}, {28'd0, s});
        chk({tag, "_flush_cnt"}, {28'd0, flush_cnt}, {28'd0, f});
        chk({tag, "_timeout"}, {31'd0, mem_timeout}, {31'd0, t});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic mr, input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic redir, input logic req, input logic rdy);
        EX_MemRead = mr; EX_rd = rd; ID_rs1 = r1; ID_use_rs1 = u1;
        ID_rs2 = r2; ID_use_rs2 = u2; EX_redirect = redir; MEM_req = req; dmem_ready = rdy;
    endtask

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        ctl("reset_ctl", C_RESET);
        tick;
        regs("reset", 0, 0, 0);
        rst = 1'b0;
        ctl("idle", C_NONE);
        tick;
        drv(1, 5, 5, 1, 0, 0, 0, 0, 1);
        ctl("lu_rs1", C_LU);
        tick;
        regs("lu_rs1", 1, 0, 0);
        drv(0, 5, 5, 1, 0, 0, 0, 0, 1);
        ctl("lu_clear", C_NONE);
        tick;
        drv(1, 7, 1, 0, 7, 1, 0, 0, 1);
        ctl("lu_rs2", C_LU);
        tick;
        drv(1, 0, 0, 1, 0, 1, 0, 0, 1);
        ctl("x0_load", C_NONE);
        tick;
        drv(1, 9, 3, 1, 9, 0, 0, 0, 1);
        ctl("rs2_unused", C_NONE);
        tick;
        drv(0, 9, 9, 1, 9, 1, 0, 0, 1);
        ctl("not_load", C_NONE);
        tick;
        regs("after_lu", 2, 0, 0);
        drv(1, 5, 5, 1, 0, 0, 1, 0, 1);
        ctl("redir_beats_lu", C_REDIR);
        tick;
        regs("redir", 2, 1, 0);
        drv(1, 5, 5, 1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            ctl($sformatf("wait3_c%0d", i), C_FREEZE);
            tick;
        end
        regs("wait3_mid", 5, 1, 0);
        dmem_ready = 1'b1;
        ctl("wait3_release_redir", C_REDIR);
        tick;
        regs("wait3_end", 5, 2, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            ctl($sformatf("tmo_c%0d", i), C_FREEZE);
            tick;
            if (i == 2) regs("tmo_after3", 8, 2, 0);
            if (i == 4) regs("tmo_after5", 10, 2, 1);
        end
        dmem_ready = 1'b1;
        ctl("tmo_release", C_NONE);
        tick;
        regs("tmo_end", 11, 2, 1);
        dmem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ctl($sformatf("drop_c%0d", i), C_FREEZE);
            tick;
        end
        MEM_req = 1'b0;
        ctl("req_drop", C_NONE);
        tick;
        regs("req_drop", 13, 2, 1);
        MEM_req = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        regs("saturate", 15, 2, 1);
        rst = 1'b1;
        EX_redirect = 1'b1;
        ctl("rst_mid_wait", C_RESET);
        tick;
        regs("rst_mid_wait", 0, 0, 0);
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        ctl("post_rst_idle", C_NONE);
        tick;
        regs("post_rst", 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
